// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode encodings and the frontend FSM states.
package alu_pkg;

  localparam int NBITS_DEF  = 8;
  localparam int COD_OP_DEF = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND
  } state_e;

  // Only the mid-frame states are guarded against a stalled sender.
  function automatic logic isTimeoutState(state_e s);
    return (s == WAIT_B) || (s == WAIT_OP);
  endfunction

endpackage

// File: rtl/alu_uart_frontend_if.sv
// Bundle of UART receive/transmit and ALU operand/result signals around the frontend.
interface alu_uart_frontend_if #(
  parameter int NBITS  = alu_pkg::NBITS_DEF,
  parameter int COD_OP = alu_pkg::COD_OP_DEF
);

  logic [NBITS-1:0]  rx_data;
  logic              rx_done;
  logic              tx_ready;
  logic [NBITS-1:0]  ALU_Result;
  logic [NBITS-1:0]  operando_A;
  logic [NBITS-1:0]  operando_B;
  logic [COD_OP-1:0] cod_operacion;
  logic [NBITS-1:0]  tx_data;
  logic              tx_start;
  logic              frame_error;

  // The frontend is the master: it owns the ALU inputs and the transmit request.
  modport master (
    input  rx_data, rx_done, tx_ready, ALU_Result,
    output operando_A, operando_B, cod_operacion, tx_data, tx_start, frame_error
  );

  modport slave (
    output rx_data, rx_done, tx_ready, ALU_Result,
    input  operando_A, operando_B, cod_operacion, tx_data, tx_start, frame_error
  );

endinterface

// File: rtl/frame_timeout_counter.sv
// Idle-cycle counter with a terminal-count strobe; used to drop frames whose sender stalls.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/alu_uart_frontend.sv
// Assembles A/B/opcode byte frames from the UART receiver into ALU operands and
// forwards the captured ALU result to the UART transmitter.
module alu_uart_frontend
  import alu_pkg::*;
#(
  parameter int NBITS          = NBITS_DEF,
  parameter int COD_OP         = COD_OP_DEF,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  alu_uart_frontend_if.master bus
);

  state_e            state_q;
  logic [NBITS-1:0]  opA_q;
  logic [NBITS-1:0]  opB_q;
  logic [COD_OP-1:0] opCode_q;
  logic [NBITS-1:0]  txData_q;
  logic              txStart_q;
  logic              frameError_q;

  logic timeoutEn;
  logic timeoutHit;
  logic byteTaken;
  logic timeoutClr;

  assign timeoutEn  = isTimeoutState(state_q);
  assign byteTaken  = bus.rx_done && timeoutEn;
  // A byte on the terminal-count cycle still wins; the counter restarts either way.
  assign timeoutClr = !timeoutEn || byteTaken || timeoutHit;

  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (timeoutClr),
    .enable_i  (timeoutEn),
    .terminal_o(timeoutHit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_A;
      opA_q        <= '0;
      opB_q        <= '0;
      opCode_q     <= '0;
      txData_q     <= '0;
      txStart_q    <= 1'b0;
      frameError_q <= 1'b0;
    end else begin
      txStart_q    <= 1'b0;
      frameError_q <= 1'b0;
      unique case (state_q)
        WAIT_A: begin
          if (bus.rx_done) begin
            opA_q   <= bus.rx_data;
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (bus.rx_done) begin
            opB_q   <= bus.rx_data;
            state_q <= WAIT_OP;
          end else if (timeoutHit) begin
            frameError_q <= 1'b1;
            state_q      <= WAIT_A;
          end
        end
        WAIT_OP: begin
          if (bus.rx_done) begin
            opCode_q <= bus.rx_data[COD_OP-1:0];
            state_q  <= EXEC;
          end else if (timeoutHit) begin
            frameError_q <= 1'b1;
            state_q      <= WAIT_A;
          end
        end
        // The ALU is combinational on the registered operands, so one cycle suffices.
        EXEC: begin
          txData_q <= bus.ALU_Result;
          state_q  <= SEND;
        end
        SEND: begin
          if (bus.tx_ready) begin
            txStart_q <= 1'b1;
            state_q   <= WAIT_A;
          end
        end
        default: state_q <= WAIT_A;
      endcase
    end
  end

  assign bus.operando_A    = opA_q;
  assign bus.operando_B    = opB_q;
  assign bus.cod_operacion = opCode_q;
  assign bus.tx_data       = txData_q;
  assign bus.tx_start      = txStart_q;
  assign bus.frame_error   = frameError_q;

endmodule

// File: tb/tb_alu_uart_frontend.sv
// Scoreboard bench: a frame-level reference model queues expected results and errors,
// and an independent monitor matches them against tx_start/frame_error pulses.
module tb_alu_uart_frontend;
  import alu_pkg::*;

  localparam int NB = 8;
  localparam int CW = 6;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_uart_frontend_if #(.NBITS(NB), .COD_OP(CW)) bus();

  alu_uart_frontend #(
    .NBITS(NB), .COD_OP(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Behavioural stand-in for the external combinational ALU.
  function automatic logic [7:0] aluRef(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return 8'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'hFF;
    endcase
  endfunction

  assign bus.ALU_Result = aluRef(bus.operando_A, bus.operando_B, bus.cod_operacion);

  typedef struct {
    logic [7:0]  data;
    int unsigned cycle;
  } txExp_t;

  txExp_t      txQ[$];
  int unsigned errQ[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cycleCnt = 0;
  bit          monOn = 1'b0;

  int         mPos;
  int         mIdle;
  int         mBusy;
  logic [7:0] mA;
  logic [7:0] mB;
  logic [5:0] mOp;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock of stimulus; the model advances by the frame rules for the edge that samples it.
  task automatic applyStimulus(input bit doRx, input logic [7:0] data, input bit rdy);
    int unsigned e;
    txExp_t t;
    @(negedge clk);
    bus.rx_done  = doRx;
    bus.rx_data  = data;
    bus.tx_ready = rdy;
    e = cycleCnt + 1;
    if (mBusy == 1) begin
      mBusy = 2;
    end else if (mBusy == 2) begin
      if (rdy) begin
        t.data  = aluRef(mA, mB, mOp);
        t.cycle = e;
        txQ.push_back(t);
        mBusy = 0;
      end
    end else if (doRx) begin
      mIdle = 0;
      case (mPos)
        0:       mA  = data;
        1:       mB  = data;
        default: mOp = data[5:0];
      endcase
      if (mPos == 2) begin
        mPos  = 0;
        mBusy = 1;
      end else begin
        mPos++;
      end
    end else if (mPos != 0) begin
      mIdle++;
      if (mIdle == TO) begin
        errQ.push_back(e);
        mPos  = 0;
        mIdle = 0;
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom), rdy);
  endtask

  task automatic sendFrame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input bit rdy);
    applyStimulus(1'b1, a, rdy);
    applyStimulus(1'b1, b, rdy);
    applyStimulus(1'b1, op, rdy);
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    reset       = 1'b1;
    bus.rx_done = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    mPos  = 0;
    mIdle = 0;
    mBusy = 0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_opA"},   32'(bus.operando_A),    32'h0);
    checkOutput({tag, "_opB"},   32'(bus.operando_B),    32'h0);
    checkOutput({tag, "_cod"},   32'(bus.cod_operacion), 32'h0);
    checkOutput({tag, "_tx"},    32'(bus.tx_data),       32'h0);
    checkOutput({tag, "_start"}, 32'(bus.tx_start),      32'h0);
    checkOutput({tag, "_ferr"},  32'(bus.frame_error),   32'h0);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation, data and cycle.
  initial begin
    bit prevStart;
    txExp_t t;
    int unsigned ec;
    prevStart = 1'b0;
    forever begin
      @(negedge clk);
      if (monOn) begin
        if (bus.tx_start === 1'b1) begin
          checkOutput("tx_start_gap", 32'(prevStart), 32'h0);
          checkOutput("tx_start_expected", 32'(txQ.size() != 0), 32'h1);
          if (txQ.size() != 0) begin
            t = txQ.pop_front();
            checkOutput("tx_data", 32'(bus.tx_data), 32'(t.data));
            checkOutput("tx_start_cycle", cycleCnt, t.cycle);
          end
        end
        if (bus.frame_error === 1'b1) begin
          checkOutput("frame_error_expected", 32'(errQ.size() != 0), 32'h1);
          if (errQ.size() != 0) begin
            ec = errQ.pop_front();
            checkOutput("frame_error_cycle", cycleCnt, ec);
          end
        end
        prevStart = (bus.tx_start === 1'b1);
      end
    end
  end

  initial begin
    logic [5:0] ops[8];
    logic [7:0] d;
    int r;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
    reset        = 1'b1;
    bus.rx_done  = 1'b0;
    bus.rx_data  = '0;
    bus.tx_ready = 1'b1;
    mPos = 0; mIdle = 0; mBusy = 0; mA = '0; mB = '0; mOp = '0;
    doReset(2);
    checkResetState("reset");
    monOn = 1'b1;

    sendFrame(8'h05, 8'h03, 8'h20, 1'b1);
    idle(4, 1'b1);
    checkOutput("add_cod", 32'(bus.cod_operacion), 32'h20);
    checkOutput("add_tx", 32'(bus.tx_data), 32'h08);

    sendFrame(8'h03, 8'h05, 8'hE2, 1'b1);
    idle(4, 1'b1);
    checkOutput("sub_cod", 32'(bus.cod_operacion), 32'h22);
    checkOutput("sub_tx", 32'(bus.tx_data), 32'hFE);

    sendFrame(8'hAA, 8'h0F, 8'h00, 1'b0);
    idle(20, 1'b0);
    idle(4, 1'b1);
    checkOutput("invalid_tx", 32'(bus.tx_data), 32'hFF);

    applyStimulus(1'b1, 8'h11, 1'b1);
    idle(TO, 1'b1);
    idle(2, 1'b1);
    checkOutput("timeout_opA_kept", 32'(bus.operando_A), 32'h11);
    sendFrame(8'h02, 8'h03, 8'h24, 1'b1);
    idle(4, 1'b1);
    checkOutput("after_timeout_tx", 32'(bus.tx_data), 32'h02);

    applyStimulus(1'b1, 8'h07, 1'b1);
    idle(TO - 1, 1'b1);
    applyStimulus(1'b1, 8'h09, 1'b1);
    applyStimulus(1'b1, 8'h26, 1'b1);
    idle(4, 1'b1);
    checkOutput("terminal_opB", 32'(bus.operando_B), 32'h09);
    checkOutput("terminal_tx", 32'(bus.tx_data), 32'h0E);

    applyStimulus(1'b1, 8'h44, 1'b1);
    applyStimulus(1'b1, 8'h55, 1'b1);
    doReset(1);
    checkResetState("midframe_reset");
    sendFrame(8'h80, 8'h01, 8'h03, 1'b1);
    idle(4, 1'b1);
    checkOutput("sra_tx", 32'(bus.tx_data), 32'hC0);

    // Random traffic, including bytes during EXEC/SEND and stalls long enough to time out.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        idle(TO + 4, 1'b1);
      end else begin
        d = 8'($urandom);
        if ($urandom_range(0, 1) == 0) d = {d[7:6], ops[$urandom_range(0, 7)]};
        applyStimulus(r < 8, d, $urandom_range(0, 3) != 0);
      end
    end

    idle(40, 1'b1);
    @(negedge clk);
    checkOutput("tx_queue_drained", txQ.size(), 32'h0);
    checkOutput("err_queue_drained", errQ.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
